// File: rtl/led_display_pattern_generator.sv
// -----------------------------------------------------------------------------
// led_display_pattern_generator
//
// Test-pattern source for a HUB75-style LED matrix driver. During bring-up it
// stands in for the frame buffer. Each handshake produces one double-row: the
// top-half row a and the bottom-half row a+16, together with their shared
// half-panel address a.
//
// Optional feature macro: LED_PTG_SCROLL_EN
//   When defined, mode 7 shows a one-column white bar that scrolls across the
//   panel. The bar only moves at a frame boundary, so a frame is never torn.
//   When undefined, mode 7 is all off and no scroll counter exists.
//
// Ports
//   clk_in          in   1      system clock, rising edge
//   reset_in        in   1      asynchronous active-high reset
//   mode_in         in   4      pattern select (0..15)
//   row_ready_in    in   1      sink can accept a row (sampled to launch only)
//   row_out         out  6*NC   {blue_bot, green_bot, red_bot,
//                                blue_top, green_top, red_top},
//                               each field NC bits, bit c = column c
//   row_valid_out   out  1      one-cycle pulse marking row_out/address valid
//   row_address_out out  4      half-panel row index 0..15
// -----------------------------------------------------------------------------
module led_display_pattern_generator #(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic [3:0]                  mode_in,
    output logic [6*NUM_COL_PIXELS-1:0] row_out,
    output logic                        row_valid_out,
    input  logic                        row_ready_in,
    output logic [3:0]                  row_address_out
);

    localparam int NC = NUM_COL_PIXELS;

    // The 4-bit address only covers a 32-row panel. The scroll step period
    // needs a clock of at least 16 Hz.
    if (NUM_ROW_PIXELS != 32) begin : g_bad_rows
        $error("led_display_pattern_generator: NUM_ROW_PIXELS must be 32");
    end
    if (SYS_CLK_FREQ < 16) begin : g_bad_clk
        $error("led_display_pattern_generator: SYS_CLK_FREQ must be >= 16");
    end

    logic [3:0]      r_mode_q;
    logic [3:0]      r_addr;
    logic            r_valid;
    logic [6*NC-1:0] r_row;

    logic            w_mode_change;
    logic [3:0]      w_sel_mode;
    logic            w_sel_par;
    logic [6*NC-1:0] w_row;

    assign w_mode_change = (mode_in != r_mode_q);

    // On a mode change the row is rebuilt from the incoming mode at address 0.
    // This is the row that the first pulse of the new mode will present.
    assign w_sel_mode = w_mode_change ? mode_in : r_mode_q;

    // The bottom row is a+16, so it has the same parity as the top row.
    // Only bit 0 of the row index matters for any pattern.
    assign w_sel_par = w_mode_change ? 1'b0 : r_addr[0];

`ifdef LED_PTG_SCROLL_EN
    localparam int STEP_CYCLES = SYS_CLK_FREQ / 16;
    localparam int CNT_W       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int OFS_W       = (NC > 1) ? $clog2(NC) : 1;

    logic [CNT_W-1:0] r_step_cnt;
    logic             r_step_pend;
    logic [OFS_W-1:0] r_offset;
    logic             w_tick;
    logic             w_frame_end;

    assign w_tick      = (r_step_cnt == CNT_W'(STEP_CYCLES - 1));
    // This is the edge after the pulse for the last address of a frame.
    assign w_frame_end = r_valid && (r_addr == 4'd15) && !w_mode_change;

    // A tick only arms a pending step. The step itself is applied at the
    // next frame boundary.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_step_cnt  <= '0;
            r_step_pend <= 1'b0;
            r_offset    <= '0;
        end else begin
            r_step_cnt <= w_tick ? '0 : r_step_cnt + 1'b1;
            if (w_frame_end && r_step_pend) begin
                r_offset    <= (r_offset == OFS_W'(NC - 1)) ? '0 : r_offset + 1'b1;
                r_step_pend <= w_tick;
            end else if (w_tick) begin
                r_step_pend <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_row = '0;
        for (int c = 0; c < NC; c++) begin : col
            logic [2:0] v_rgb;
            v_rgb = 3'b000;
            case (w_sel_mode)
                4'd1:    v_rgb = 3'b001;
                4'd2:    v_rgb = 3'b010;
                4'd3:    v_rgb = 3'b100;
                4'd4:    v_rgb = 3'b111;
                4'd5:    v_rgb = (c[0] == 1'b0) ? 3'b111 : 3'b000;
                4'd6:    v_rgb = ((w_sel_par ^ c[0]) == 1'b0) ? 3'b111 : 3'b000;
`ifdef LED_PTG_SCROLL_EN
                4'd7:    v_rgb = (c == int'(r_offset)) ? 3'b111 : 3'b000;
`endif
                default: v_rgb = 3'b000;
            endcase
            // Every pattern lights the top and bottom rows alike.
            w_row[0*NC + c] = v_rgb[0];
            w_row[1*NC + c] = v_rgb[1];
            w_row[2*NC + c] = v_rgb[2];
            w_row[3*NC + c] = v_rgb[0];
            w_row[4*NC + c] = v_rgb[1];
            w_row[5*NC + c] = v_rgb[2];
        end
    end

    // A mode change restarts the frame. Otherwise the pulse/advance cycle
    // alternates. Ready only launches a pulse; the sink must take every pulse.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_mode_q <= 4'd0;
            r_addr   <= 4'd0;
            r_valid  <= 1'b0;
            r_row    <= '0;
        end else begin
            r_mode_q <= mode_in;
            if (w_mode_change) begin
                r_addr  <= 4'd0;
                r_valid <= 1'b0;
                r_row   <= w_row;
            end else if (r_valid) begin
                r_valid <= 1'b0;
                r_addr  <= r_addr + 4'd1;
            end else if (row_ready_in) begin
                r_valid <= 1'b1;
                r_row   <= w_row;
            end
        end
    end

    assign row_out         = r_row;
    assign row_valid_out   = r_valid;
    assign row_address_out = r_addr;

endmodule

// File: tb/tb_led_display_pattern_generator.sv
module tb_led_display_pattern_generator;

    localparam int NC = 64;
    localparam int RW = 6 * NC;

    logic          clk_in;
    logic          reset_in;
    logic [3:0]    mode_in;
    logic [RW-1:0] row_out;
    logic          row_valid_out;
    logic          row_ready_in;
    logic [3:0]    row_address_out;

    int checks = 0;
    int errors = 0;

    led_display_pattern_generator #(
        .SYS_CLK_FREQ  (100_000_000),
        .NUM_ROW_PIXELS(32),
        .NUM_COL_PIXELS(NC)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .mode_in        (mode_in),
        .row_out        (row_out),
        .row_valid_out  (row_valid_out),
        .row_ready_in   (row_ready_in),
        .row_address_out(row_address_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    localparam logic [NC-1:0] ONES = {NC{1'b1}};
    localparam logic [NC-1:0] ZERO = '0;
    localparam logic [NC-1:0] EVEN = {(NC/2){2'b01}};
    localparam logic [NC-1:0] ODD  = {(NC/2){2'b10}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Steps until a pulse is seen, with a bounded number of cycles.
    task automatic wait_pulse(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (row_valid_out) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_pulse_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        logic [3:0] exp_addr;
        int         npulse;
        logic       bad_valid;
        logic       bad_addr;

        reset_in     = 1'b1;
        mode_in      = 4'd0;
        row_ready_in = 1'b0;
        repeat (3) tick();
        chk("reset_valid", 32'(row_valid_out), 32'd0);
        chk("reset_addr", 32'(row_address_out), 32'd0);
        chk_row("reset_row", row_out, '0);

        // Mode 0, ready high: pulses with addresses 0..15, then a wrap to 0.
        reset_in     = 1'b0;
        row_ready_in = 1'b1;
        for (int k = 0; k < 17; k++) begin
            wait_pulse("m0");
            chk("m0_addr", 32'(row_address_out), 32'(k % 16));
            chk_row("m0_row", row_out, '0);
            if (k < 16) begin
                tick();
                chk("m0_gap_valid", 32'(row_valid_out), 32'd0);
                chk("m0_gap_addr", 32'(row_address_out), 32'((k + 1) % 16));
            end
        end

        // Mode 1 with ready toggling on every cycle.
        mode_in = 4'd1;
        tick();
        chk("m1_change_valid", 32'(row_valid_out), 32'd0);
        chk("m1_change_addr", 32'(row_address_out), 32'd0);
        exp_addr = 4'd0;
        npulse   = 0;
        for (int i = 0; i < 10; i++) begin
            row_ready_in = (i % 2 == 0);
            tick();
            if (row_valid_out) begin
                chk("m1_addr", 32'(row_address_out), 32'(exp_addr));
                chk_row("m1_row", row_out, {ZERO, ZERO, ONES, ZERO, ZERO, ONES});
                exp_addr = exp_addr + 4'd1;
                npulse++;
            end
        end
        chk("m1_pulse_count", 32'(npulse), 32'd5);

        // Mode 3 up to address 9, then a switch to mode 4.
        mode_in      = 4'd3;
        row_ready_in = 1'b1;
        tick();
        chk("m3_change_addr", 32'(row_address_out), 32'd0);
        for (int k = 0; k < 10; k++) begin
            wait_pulse("m3");
            chk("m3_addr", 32'(row_address_out), 32'(k));
        end
        chk_row("m3_row", row_out, {ONES, ZERO, ZERO, ONES, ZERO, ZERO});
        mode_in = 4'd4;
        tick();
        chk("m4_change_valid", 32'(row_valid_out), 32'd0);
        chk("m4_change_addr", 32'(row_address_out), 32'd0);
        wait_pulse("m4");
        chk("m4_addr", 32'(row_address_out), 32'd0);
        chk_row("m4_row", row_out, {6{ONES}});

        // Mode 6: the checkerboard parity follows the row.
        mode_in = 4'd6;
        tick();
        chk("m6_change_valid", 32'(row_valid_out), 32'd0);
        chk("m6_change_addr", 32'(row_address_out), 32'd0);
        wait_pulse("m6a0");
        chk("m6a0_addr", 32'(row_address_out), 32'd0);
        chk("m6a0_rt_b0", 32'(row_out[0]), 32'd1);
        chk("m6a0_rt_b1", 32'(row_out[1]), 32'd0);
        chk("m6a0_rb_b0", 32'(row_out[3*NC]), 32'd1);
        chk("m6a0_rb_b1", 32'(row_out[3*NC+1]), 32'd0);
        chk_row("m6a0_row", row_out, {6{EVEN}});
        wait_pulse("m6a1");
        chk("m6a1_addr", 32'(row_address_out), 32'd1);
        chk("m6a1_rt_b0", 32'(row_out[0]), 32'd0);
        chk("m6a1_rt_b1", 32'(row_out[1]), 32'd1);
        chk("m6a1_rb_b0", 32'(row_out[3*NC]), 32'd0);
        chk("m6a1_rb_b1", 32'(row_out[3*NC+1]), 32'd1);
        chk_row("m6a1_row", row_out, {6{ODD}});

        // Stall: hold ready low at address 5 for 50 cycles.
        for (int k = 2; k < 5; k++) begin
            wait_pulse("m6adv");
            chk("m6adv_addr", 32'(row_address_out), 32'(k));
        end
        row_ready_in = 1'b0;
        tick();
        bad_valid = 1'b0;
        bad_addr  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (row_valid_out) bad_valid = 1'b1;
            if (row_address_out != 4'd5) bad_addr = 1'b1;
        end
        chk("stall_no_pulse", 32'(bad_valid), 32'd0);
        chk("stall_addr_stable", 32'(bad_addr), 32'd0);
        chk("stall_addr", 32'(row_address_out), 32'd5);
        row_ready_in = 1'b1;
        wait_pulse("resume");
        chk("resume_addr", 32'(row_address_out), 32'd5);
        chk_row("resume_row", row_out, {6{ODD}});

        // Asynchronous reset in the middle of a pulse.
        #2;
        reset_in = 1'b1;
        #1;
        chk("areset_valid", 32'(row_valid_out), 32'd0);
        chk("areset_addr", 32'(row_address_out), 32'd0);
        chk_row("areset_row", row_out, '0);
        repeat (2) tick();
        reset_in = 1'b0;
        wait_pulse("post_reset");
        chk("post_reset_addr", 32'(row_address_out), 32'd0);
        chk_row("post_reset_row", row_out, {6{EVEN}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_display_pattern_generator.md
Name: led_display_pattern_generator

Overview:
- Test-pattern source for the HUB75-style LED matrix driver.
- Produces one double-row (top half row N and bottom half row N+16) per handshake, with a 4-bit row address, for a selectable pattern mode.
- Sits upstream of the display driver PHY and replaces the frame buffer during bring-up.

Parameters:
- SYS_CLK_FREQ, 100_000_000: system clock in Hz; sets the scroll step period (optional feature only).
- NUM_ROW_PIXELS, 32: panel rows; address range is NUM_ROW_PIXELS/2 = 16.
- NUM_COL_PIXELS, 64: pixels per row.

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- mode_in  input  4  pattern select.
- row_out  output  6*NUM_COL_PIXELS  packed row data. LSB-first fields, each NUM_COL_PIXELS wide, bit c = column c: red_top, green_top, blue_top, red_bot, green_bot, blue_bot.
- row_valid_out  output  1  single-cycle pulse; row_out/row_address_out are valid in that cycle.
- row_ready_in  input  1  sink can accept a row.
- row_address_out  output  4  half-panel row index 0..15 of the row on row_out.

Behaviour:
- Reset (async, active-high): row_valid_out=0, row_address_out=0, row_out=0, registered mode=0, scroll offset=0.
- All outputs are registered.
- Mode tracking:
  - mode_q registers mode_in every cycle.
  - On any edge where mode_in != mode_q: address<=0, valid<=0, row_out recomputed for the new mode; no pulse that cycle.
  - The first row of the new mode therefore carries address 0.
- Issue rule, on an edge with no mode change:
  - If row_valid_out==0 and row_ready_in==1: assert row_valid_out for exactly one cycle, presenting the row for the current address.
  - If row_valid_out==1: deassert it and increment the address.
  - The sink must take every pulse. Ready is sampled only to launch a pulse; it is not held against.
- Resulting throughput: at most one row per 2 cycles. Address increments exactly once per pulse.
- Address wraps 15 -> 0.
- Ready low: no pulse and no address change; address stays stable indefinitely.
- Row content is a function of mode_q, address a (top row r=a, bottom row r=a+16) and column c:
  - 0: all off.
  - 1: all red.
  - 2: all green.
  - 3: all blue.
  - 4: all white (R=G=B=1).
  - 5: vertical stripes; all colours lit where c[0]==0.
  - 6: checkerboard; white where (r[0]^c[0])==0.
  - 7..15: all off, except mode 7 when the optional feature is enabled.
- row_out is updated on the same edge as row_valid_out rises. It is held while idle.

Optional Feature:
- Macro LED_PTG_SCROLL_EN.
- Defined:
  - Mode 7 is a scrolling single-column white bar at column (offset mod NUM_COL_PIXELS), all rows lit.
  - The offset increments every SYS_CLK_FREQ/16 cycles using a free-running counter that resets on reset_in.
  - The offset updates only on the edge after a pulse for address 15, so a frame is never torn.
- Undefined: mode 7 is all off; no counter is synthesised.

Test Plan:
- Reset then hold ready=1, mode=0 -> pulses every 2 cycles; address sequence 0,1,...,15,0; row_out all zero.
- mode=1, toggle ready every cycle for 10 cycles -> each pulse has address one greater than the previous pulse; red_top and red_bot are all-ones; green and blue fields are zero.
- Change mode 3 -> 4 mid-frame (address 9) -> the next sampled address is 0 with valid=0; the next pulse carries address 0 with white data.
- mode=6 -> pulse at address 0 has red_top bit0=1, bit1=0; pulse at address 1 has red_top bit0=0, bit1=1. Bottom rows 16 and 17 follow the same parity.
- ready held 0 for 50 cycles at address 5 -> no pulses and address stays 5; ready=1 -> next pulse carries address 5.
- Assert reset_in mid-pulse -> valid and address go to 0 immediately (asynchronously); after release, the first pulse carries address 0.
